// File: rtl/wb_dsp_master_arbiter_if.sv
// wb_dsp_master_arbiter_if: request-port bundle between the arbiter and the wishbone master.
interface wb_dsp_master_arbiter_if #(parameter int dw = 32, parameter int aw = 32);
   logic          start;
   logic [aw-1:0] address;
   logic [3:0]    selection;
   logic          write;
   logic [dw-1:0] data_wr;
   logic          active;
   logic [dw-1:0] data_rd;
   modport master(output start, address, selection, write, data_wr, input active, data_rd);
   modport slave(input start, address, selection, write, data_wr, output active, data_rd);
endinterface

// File: rtl/wb_dsp_master_arbiter.sv
// wb_dsp_master_arbiter: round-robin sharing of one wishbone master port; WB_DSP_ARB_TIMEOUT_EN adds a watchdog.
module wb_dsp_master_arbiter #(
   parameter int NREQ = 4,
   parameter int dw = 32,
   parameter int aw = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                 wb_clk,
   input  logic                 wb_rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*aw-1:0]   req_address,
   input  logic [NREQ*4-1:0]    req_selection,
   input  logic [NREQ-1:0]      req_write,
   input  logic [NREQ*dw-1:0]   req_data_wr,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic [NREQ-1:0]      err,
   output logic [dw-1:0]        rd_data,
   output logic                 busy,
   wb_dsp_master_arbiter_if.master m
);
   localparam int LW = NREQ > 1 ? $clog2(NREQ) : 1;
   typedef enum logic [2:0] {IDLE, START, ISSUED, BUSY, DONE} state_t;
   state_t state;
   logic [LW-1:0] last_gnt, win, idx;
   logic [aw-1:0] addr_a [NREQ];
   logic [3:0]    sel_a [NREQ];
   logic [dw-1:0] dat_a [NREQ];
   logic tmo;
   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign addr_a[i] = req_address[i*aw +: aw];
      assign sel_a[i] = req_selection[i*4 +: 4];
      assign dat_a[i] = req_data_wr[i*dw +: dw];
   end
   // scan downward so the nearest set bit after last_gnt wins
   always_comb begin
      win = last_gnt;
      idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = LW'((int'(last_gnt) + k) % NREQ);
         if (req[idx]) win = idx;
      end
   end
`ifdef WB_DSP_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   assign tmo = (state == ISSUED || state == BUSY) && cnt == CW'(TIMEOUT - 1);
   always_ff @(posedge wb_clk)
      if (wb_rst) begin
         cnt <= '0;
         err <= '0;
      end else begin
         cnt <= state == START ? '0 : cnt + 1'b1;
         err <= tmo ? gnt : '0;
      end
`else
   assign tmo = 1'b0;
   assign err = '0;
`endif
   always_ff @(posedge wb_clk)
      if (wb_rst) begin
         state <= IDLE;
         gnt <= '0;
         done <= '0;
         busy <= 1'b0;
         rd_data <= '0;
         last_gnt <= LW'(NREQ - 1);
         m.start <= 1'b0;
         m.address <= '0;
         m.selection <= '0;
         m.write <= 1'b0;
         m.data_wr <= '0;
      end else begin
         done <= '0;
         m.start <= 1'b0;
         if (tmo) begin
            gnt <= '0;
            busy <= 1'b0;
            state <= IDLE;
         end else
            case (state)
               IDLE: if (|req) begin
                  gnt <= NREQ'(1) << win;
                  last_gnt <= win;
                  m.address <= addr_a[win];
                  m.selection <= sel_a[win];
                  m.write <= req_write[win];
                  m.data_wr <= dat_a[win];
                  busy <= 1'b1;
                  state <= START;
               end
               START: begin
                  m.start <= 1'b1;
                  state <= ISSUED;
               end
               ISSUED: if (m.active) state <= BUSY;
               BUSY: if (!m.active) begin
                  rd_data <= m.data_rd;
                  done <= gnt;
                  state <= DONE;
               end
               DONE: begin
                  gnt <= '0;
                  busy <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
      end
endmodule

// File: tb/tb_wb_dsp_master_arbiter.sv
// tb_wb_dsp_master_arbiter: directed checks of arbitration order, handshake timing and reset.
module tb_wb_dsp_master_arbiter;
   logic clk = 1'b0, wb_rst = 1'b1;
   logic [3:0] req = '0, req_write = '0, gnt, done, err;
   logic [127:0] req_address = '0, req_data_wr = '0;
   logic [15:0] req_selection = '0;
   logic [31:0] rd_data;
   logic busy;
   int passed = 0, total = 0;
   wb_dsp_master_arbiter_if #(.dw(32), .aw(32)) bus();
   wb_dsp_master_arbiter #(.NREQ(4), .dw(32), .aw(32), .TIMEOUT(16)) dut (
      .wb_clk(clk), .wb_rst(wb_rst), .req(req), .req_address(req_address),
      .req_selection(req_selection), .req_write(req_write), .req_data_wr(req_data_wr),
      .gnt(gnt), .done(done), .err(err), .rd_data(rd_data), .busy(busy), .m(bus)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   // master model: waits for start, holds active for `hold` cycles, then returns data
   task automatic serve(input int hold, input logic [31:0] d, input logic [3:0] drop,
                        output logic [3:0] g, output logic [3:0] dn, output int lat);
      int n = 0;
      g = '0;
      dn = '0;
      lat = -1;
      while (!bus.start && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.start) return;
      g = gnt;
      lat = n;
      bus.active = 1'b1;
      req = req & ~drop;
      repeat (hold) @(negedge clk);
      bus.active = 1'b0;
      bus.data_rd = d;
      @(negedge clk);
      dn = done;
   endtask
   task automatic test_reset;
      wb_rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (gnt !== 4'b0) $display("FAIL reset_gnt got %h exp 0", gnt); else passed++;
      total++; if (done !== 4'b0) $display("FAIL reset_done got %h exp 0", done); else passed++;
      total++; if (err !== 4'b0) $display("FAIL reset_err got %h exp 0", err); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
      total++; if (bus.start !== 1'b0) $display("FAIL reset_start got %b exp 0", bus.start); else passed++;
      total++; if (bus.address !== 32'h0) $display("FAIL reset_address got %h exp 0", bus.address); else passed++;
      total++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data got %h exp 0", rd_data); else passed++;
      wb_rst = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_round_robin;
      logic [3:0] g, dn;
      int lat;
      for (int r = 0; r < 2; r++) begin
         req = 4'hF;
         for (int i = 0; i < 4; i++) begin
            serve(1, 32'h10 + i, 4'b0, g, dn, lat);
            total++; if (g !== 4'b1 << i) $display("FAIL rr_grant r%0d i%0d got %h exp %h", r, i, g, 4'b1 << i); else passed++;
            total++; if (dn !== 4'b1 << i) $display("FAIL rr_done r%0d i%0d got %h exp %h", r, i, dn, 4'b1 << i); else passed++;
            req = req & ~dn;
         end
         req = '0;
         repeat (2) @(negedge clk);
      end
   endtask
   task automatic test_single;
      logic [3:0] g, dn;
      int lat;
      req_address[31:0] = 32'h100;
      req_selection[3:0] = 4'hF;
      req_write[0] = 1'b0;
      req = 4'b0001;
      serve(3, 32'hDEADBEEF, 4'b0, g, dn, lat);
      total++; if (lat !== 2) $display("FAIL single_latency got %0d exp 2", lat); else passed++;
      total++; if (g !== 4'b0001) $display("FAIL single_grant got %h exp 1", g); else passed++;
      total++; if (bus.address !== 32'h100) $display("FAIL single_address got %h exp 100", bus.address); else passed++;
      total++; if (bus.write !== 1'b0) $display("FAIL single_write got %b exp 0", bus.write); else passed++;
      total++; if (bus.selection !== 4'hF) $display("FAIL single_selection got %h exp f", bus.selection); else passed++;
      total++; if (dn !== 4'b0001) $display("FAIL single_done got %h exp 1", dn); else passed++;
      total++; if (rd_data !== 32'hDEADBEEF) $display("FAIL single_rd_data got %h exp deadbeef", rd_data); else passed++;
      req = '0;
      @(negedge clk);
      total++; if (done !== 4'b0) $display("FAIL single_done_pulse got %h exp 0", done); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL single_busy_after got %b exp 0", busy); else passed++;
      @(negedge clk);
   endtask
   task automatic test_sticky;
      logic [3:0] g, dn;
      int lat;
      req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         serve(1, 32'h0, 4'b0, g, dn, lat);
         total++; if (g !== (i % 2 == 0 ? 4'b0100 : 4'b0001)) $display("FAIL sticky_grant i%0d got %h exp %h", i, g, i % 2 == 0 ? 4'b0100 : 4'b0001); else passed++;
      end
      req = '0;
      repeat (2) @(negedge clk);
   endtask
   task automatic test_mid_drop;
      logic [3:0] g, dn;
      int lat;
      req_address[63:32] = 32'h2000;
      req_write[1] = 1'b1;
      req_data_wr[63:32] = 32'hCAFE0001;
      req = 4'b0010;
      serve(2, 32'h1234, 4'b0010, g, dn, lat);
      total++; if (g !== 4'b0010) $display("FAIL drop_grant got %h exp 2", g); else passed++;
      total++; if (dn !== 4'b0010) $display("FAIL drop_done got %h exp 2", dn); else passed++;
      total++; if (bus.write !== 1'b1) $display("FAIL drop_write got %b exp 1", bus.write); else passed++;
      total++; if (bus.data_wr !== 32'hCAFE0001) $display("FAIL drop_data_wr got %h exp cafe0001", bus.data_wr); else passed++;
      total++; if (rd_data !== 32'h1234) $display("FAIL drop_rd_data got %h exp 1234", rd_data); else passed++;
      repeat (3) @(negedge clk);
      total++; if (bus.address !== 32'h2000) $display("FAIL drop_address_held got %h exp 2000", bus.address); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL drop_busy got %b exp 0", busy); else passed++;
   endtask
   task automatic test_reset_busy;
      logic [3:0] g, dn, seen;
      int lat, n;
      n = 0;
      req = 4'b0100;
      while (!bus.start && n < 20) begin
         @(negedge clk);
         n++;
      end
      bus.active = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b1) $display("FAIL rstb_busy_before got %b exp 1", busy); else passed++;
      total++; if (gnt !== 4'b0100) $display("FAIL rstb_gnt_before got %h exp 4", gnt); else passed++;
      wb_rst = 1'b1;
      @(negedge clk);
      wb_rst = 1'b0;
      bus.active = 1'b0;
      req = '0;
      total++; if (busy !== 1'b0) $display("FAIL rstb_busy got %b exp 0", busy); else passed++;
      total++; if (gnt !== 4'b0) $display("FAIL rstb_gnt got %h exp 0", gnt); else passed++;
      total++; if (bus.start !== 1'b0) $display("FAIL rstb_start got %b exp 0", bus.start); else passed++;
      seen = done;
      repeat (4) begin
         @(negedge clk);
         seen = seen | done;
      end
      total++; if (seen !== 4'b0) $display("FAIL rstb_no_done got %h exp 0", seen); else passed++;
      req = 4'b1001;
      serve(1, 32'h0, 4'b0, g, dn, lat);
      total++; if (g !== 4'b0001) $display("FAIL rstb_next_grant got %h exp 1", g); else passed++;
      req = '0;
      repeat (2) @(negedge clk);
   endtask
`ifdef WB_DSP_ARB_TIMEOUT_EN
   task automatic test_timeout;
      logic [3:0] dsum;
      int n;
      n = 0;
      dsum = '0;
      req = 4'b0001;
      while (!bus.start && n < 20) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (err === 4'b0 && n < 40) begin
         @(negedge clk);
         n++;
         dsum = dsum | done;
      end
      req = '0;
      total++; if (n !== 16) $display("FAIL tmo_cycles got %0d exp 16", n); else passed++;
      total++; if (err !== 4'b0001) $display("FAIL tmo_err got %h exp 1", err); else passed++;
      total++; if (dsum !== 4'b0) $display("FAIL tmo_done got %h exp 0", dsum); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL tmo_busy got %b exp 0", busy); else passed++;
      @(negedge clk);
      total++; if (err !== 4'b0) $display("FAIL tmo_err_pulse got %h exp 0", err); else passed++;
   endtask
`endif
   initial begin
      bus.active = 1'b0;
      bus.data_rd = '0;
      test_reset;
      test_round_robin;
      test_single;
      test_sticky;
      test_mid_drop;
      test_reset_busy;
`ifdef WB_DSP_ARB_TIMEOUT_EN
      test_timeout;
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
